// File: rtl/spi_tx_responder.sv
// spi_tx_responder: SPI mode-0 peripheral-side transmitter.
// Oversamples SCLK / CS_n in the clk domain. Bytes from the controller FSM
// go through a one-deep holding register and are shifted out MSB-first on
// CIPO. If no byte is held at a byte boundary, IDLE_BYTE is sent instead.
//
// Handshake: a write is accepted in any cycle where tx_valid && tx_ready
// are both high at the rising clk edge. tx_ready is the inverse of the
// registered hold_full flag. tx_data must stay stable while tx_valid is
// high and tx_ready is low. tx_valid may stay asserted across transfers.
module spi_tx_responder #(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       byte_sent,
    output logic       underrun,
    output logic       frame_abort,
    output logic       o_dbg_state,
    output logic [2:0] o_dbg_bit_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [0:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_cur_is_data;
    logic [7:0] r_hold_data;
    logic       r_hold_full;
    logic       r_cipo;
    logic       r_cipo_oe;
    logic       r_byte_sent;
    logic       r_underrun;
    logic       r_frame_abort;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_active;
    logic w_load;
    logic w_tx_accept;

    // Synchronize the host pins; CS resets deasserted, SCLK resets low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    assign w_active    = (r_state == ST_ACTIVE);
    // A byte boundary: frame start, or the falling edge after the 8th rise.
    assign w_load      = (w_cs_fall && !w_active) ||
                         (w_active && w_sclk_fall && (r_bit_cnt == 3'd0));
    assign w_tx_accept = tx_valid && !r_hold_full;

    // Frame FSM, holding register, shifter and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_cur_is_data <= 1'b0;
            r_hold_data   <= 8'd0;
            r_hold_full   <= 1'b0;
            r_cipo        <= 1'b0;
            r_cipo_oe     <= 1'b0;
            r_byte_sent   <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_byte_sent   <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_abort <= 1'b0;

            // Only accepted while empty, so it never collides with a load
            // that drains the register in the same cycle.
            if (w_tx_accept) begin
                r_hold_data <= tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_cs_rise) begin
                // Partial byte is dropped; the held byte stays for next frame.
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_cipo_oe <= 1'b0;
                r_cipo    <= 1'b0;
                if (r_bit_cnt != 3'd0) begin
                    r_frame_abort <= 1'b1;
                end
            end else if (w_load) begin
                if (w_cs_fall) begin
                    r_state   <= ST_ACTIVE;
                    r_cipo_oe <= 1'b1;
                end
                if (r_hold_full) begin
                    r_shift       <= r_hold_data;
                    r_hold_full   <= 1'b0;
                    r_cur_is_data <= 1'b1;
                    r_cipo        <= r_hold_data[7];
                end else begin
                    r_shift       <= IDLE_BYTE;
                    r_cur_is_data <= 1'b0;
                    r_underrun    <= 1'b1;
                    r_cipo        <= IDLE_BYTE[7];
                end
            end else if (w_active && w_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if ((r_bit_cnt == 3'd7) && r_cur_is_data) begin
                    r_byte_sent <= 1'b1;
                end
            end else if (w_active && w_sclk_fall) begin
                // bit_cnt != 0 here: the zero case is the load branch above.
                r_shift <= {r_shift[6:0], 1'b0};
                r_cipo  <= r_shift[6];
            end
        end
    end

    assign CIPO          = r_cipo;
    assign cipo_oe       = r_cipo_oe;
    assign tx_ready      = ~r_hold_full;
    assign byte_sent     = r_byte_sent;
    assign underrun      = r_underrun;
    assign frame_abort   = r_frame_abort;
    assign o_dbg_state   = r_state;
    assign o_dbg_bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_spi_tx_responder.sv
// Bench for spi_tx_responder: a host-side pin driver with a byte-stream
// reference model (hold slot, current byte, bit position within frame).
module tb_spi_tx_responder;

    localparam logic [7:0] IDLE = 8'hFF;
    localparam int         PH   = 6;   // clk cycles per SCLK phase (clk/12)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCLK = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       CIPO;
    logic       cipo_oe;
    logic       tx_ready;
    logic       byte_sent;
    logic       underrun;
    logic       frame_abort;
    logic       o_dbg_state;
    logic [2:0] o_dbg_bit_cnt;

    int n_checks = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    logic [7:0] m_cur = 8'h00;
    bit         m_cur_data = 1'b0;
    int         m_bits = 0;
    int         exp_sent = 0;
    int         exp_under = 0;
    int         exp_abort = 0;

    // Observed pulse counts and host-received bytes
    int         cnt_sent = 0;
    int         cnt_under = 0;
    int         cnt_abort = 0;
    logic [7:0] host_sr = 8'h00;
    logic [7:0] rx_q[$];

    spi_tx_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .SCLK          (SCLK),
        .spi_cs_n      (spi_cs_n),
        .CIPO          (CIPO),
        .cipo_oe       (cipo_oe),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .byte_sent     (byte_sent),
        .underrun      (underrun),
        .frame_abort   (frame_abort),
        .o_dbg_state   (o_dbg_state),
        .o_dbg_bit_cnt (o_dbg_bit_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_sent)   cnt_sent++;
            if (underrun)    cnt_under++;
            if (frame_abort) cnt_abort++;
        end
    end

    // Time limit
    initial begin
        #900_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Byte boundary in the model: take the held byte or fall back to idle.
    task automatic m_load();
        if (m_full) begin
            m_cur      = m_hold;
            m_full     = 1'b0;
            m_cur_data = 1'b1;
        end else begin
            m_cur      = IDLE;
            m_cur_data = 1'b0;
            exp_under++;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        check("tx_ready_before_write", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        m_hold   = b;
        m_full   = 1'b1;
    endtask

    task automatic cs_assert();
        spi_cs_n = 1'b0;
        m_bits   = 0;
        m_load();
        wait_clks(PH);
        check("cipo_oe_assert", cipo_oe, 1);
        check("state_active", o_dbg_state, 1);
        check("tx_ready_after_cs", tx_ready, !m_full);
    endtask

    task automatic sclk_rise();
        int idx;
        idx = 7 - (m_bits % 8);
        check("cipo_bit", CIPO, m_cur[idx]);
        host_sr = {host_sr[6:0], CIPO};
        SCLK = 1'b1;
        m_bits++;
        if (m_bits % 8 == 0) begin
            rx_q.push_back(host_sr);
            if (m_cur_data) exp_sent++;
        end
        wait_clks(PH);
        check("tx_ready_hi_phase", tx_ready, !m_full);
    endtask

    task automatic sclk_fall();
        SCLK = 1'b0;
        if (m_bits % 8 == 0) m_load();
        wait_clks(PH);
        check("tx_ready_lo_phase", tx_ready, !m_full);
    endtask

    task automatic cs_deassert();
        spi_cs_n = 1'b1;
        if (m_bits % 8 != 0) exp_abort++;
        m_bits = 0;
        wait_clks(PH);
        check("cipo_oe_deassert", cipo_oe, 0);
        check("cipo_deassert", CIPO, 0);
        check("bit_cnt_deassert", o_dbg_bit_cnt, 0);
        check("state_idle", o_dbg_state, 0);
    endtask

    task automatic check_counts();
        check("byte_sent_count", cnt_sent, exp_sent);
        check("underrun_count", cnt_under, exp_under);
        check("frame_abort_count", cnt_abort, exp_abort);
    endtask

    // One CS frame of nbits SCLK rises; CS is raised while SCLK is still
    // high after the last rise, so no trailing byte boundary is created.
    task automatic frame(input int nbits, input int wr_at, input logic [7:0] wr_byte, input bit rnd_wr);
        cs_assert();
        for (int i = 0; i < nbits; i++) begin
            sclk_rise();
            if (i == wr_at && !m_full) write_byte(wr_byte);
            if (rnd_wr && !m_full && ($urandom_range(0, 1) == 1)) write_byte(8'($urandom));
            if (i != nbits - 1) sclk_fall();
        end
        cs_deassert();
        SCLK = 1'b0;
        wait_clks(PH);
        check_counts();
    endtask

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_cipo", CIPO, 0);
        check("rst_cipo_oe", cipo_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_pulses", {byte_sent, underrun, frame_abort}, 0);
        rst_n = 1'b1;
        wait_clks(PH);

        // Single byte 8'hA7
        write_byte(8'hA7);
        check("tx_ready_after_write", tx_ready, 0);
        frame(8, -1, 8'h00, 1'b0);
        check("rx_a7", rx_q.pop_front(), 8'hA7);

        // 8'h3C followed by an underrun idle byte
        write_byte(8'h3C);
        frame(16, -1, 8'h00, 1'b0);
        check("rx_3c", rx_q.pop_front(), 8'h3C);
        check("rx_idle_after_3c", rx_q.pop_front(), IDLE);

        // Back-to-back: second byte written during bit 3
        write_byte(8'h01);
        frame(16, 2, 8'h80, 1'b0);
        check("rx_01", rx_q.pop_front(), 8'h01);
        check("rx_80", rx_q.pop_front(), 8'h80);

        // Abort after 4 bits, then a frame with nothing held
        write_byte(8'hF0);
        frame(4, -1, 8'h00, 1'b0);
        rx_q.delete();
        frame(8, -1, 8'h00, 1'b0);
        check("rx_idle_after_abort", rx_q.pop_front(), IDLE);

        // SCLK toggling with CS high is ignored and the held byte stays
        write_byte(8'hA5);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1;
            wait_clks(PH);
            SCLK = 1'b0;
            wait_clks(PH);
            check("idle_cipo", CIPO, 0);
            check("idle_cipo_oe", cipo_oe, 0);
            check("idle_bit_cnt", o_dbg_bit_cnt, 0);
            check("idle_held", tx_ready, 0);
        end
        frame(8, -1, 8'h00, 1'b0);
        check("rx_a5", rx_q.pop_front(), 8'hA5);

        // Asynchronous reset during bit 5 of 8'h55
        write_byte(8'h55);
        cs_assert();
        for (int i = 0; i < 5; i++) begin
            sclk_rise();
            sclk_fall();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cipo", CIPO, 0);
        check("arst_cipo_oe", cipo_oe, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_pulses", {byte_sent, underrun, frame_abort}, 0);
        check("arst_state", o_dbg_state, 0);
        check("arst_bit_cnt", o_dbg_bit_cnt, 0);
        spi_cs_n = 1'b1;
        SCLK     = 1'b0;
        m_full   = 1'b0;
        m_bits   = 0;
        rx_q.delete();
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(PH);
        check("post_rst_tx_ready", tx_ready, 1);
        frame(8, -1, 8'h00, 1'b0);
        check("rx_idle_after_rst", rx_q.pop_front(), IDLE);

        // Randomized frames, writes and aborts
        for (int f = 0; f < 8; f++) begin
            int nb;
            if (!m_full && ($urandom_range(0, 1) == 1)) write_byte(8'($urandom));
            nb = 8 * $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
            frame(nb, -1, 8'h00, 1'b1);
            rx_q.delete();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_tx_responder.md
# spi_tx_responder

SPI mode-0 peripheral-side transmitter that returns bytes (classification result, status code) from the FPGA to the external host on CIPO, the outbound counterpart of the image-receiving SPI peripheral. It runs entirely in the `clk` domain, oversampling SCLK and CS_n through synchronizers. It accepts bytes from the controller FSM through a one-deep holding register with a valid/ready handshake, shifts them out MSB-first, and substitutes an idle byte on underrun.

## Interface
- `IDLE_BYTE`, default 8'hFF: byte shifted out when no data is held at a byte boundary.
- `SYNC_STAGES`, default 2: synchronizer depth for SCLK and spi_cs_n (minimum 2).
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `SCLK` input 1: SPI clock from the host, asynchronous, idles low.
- `spi_cs_n` input 1: chip select from the host, asynchronous, active-low.
- `CIPO` output 1: serial data to the host, registered.
- `cipo_oe` output 1: pad output enable; high while the synchronized CS is asserted.
- `tx_data` input 8: byte offered by the FSM.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: holding register empty; a write is accepted on `tx_valid && tx_ready`.
- `byte_sent` output 1: one-cycle pulse when a held (non-idle) byte has completed its 8th SCLK rising edge.
- `underrun` output 1: one-cycle pulse when `IDLE_BYTE` is loaded because the holding register is empty.
- `frame_abort` output 1: one-cycle pulse when CS deasserts with 1–7 bits of the current byte sent.

## Operation
- Synchronize SCLK and CS_n through `SYNC_STAGES` flops. Register one further stage for edge detection: `sclk_rise`, `sclk_fall`, `cs_fall` (assert), `cs_rise` (deassert).
- State is IDLE or ACTIVE.
  - IDLE→ACTIVE on `cs_fall`.
  - ACTIVE→IDLE on `cs_rise`.
  - SCLK edges in IDLE are ignored.
- Holding register: `hold_data[7:0]`, `hold_full`. `tx_ready = !hold_full`, registered.
- **Load event** (on `cs_fall`, and on `sclk_fall` while ACTIVE with `bit_cnt == 0`):
  - If `hold_full`: shift register ← `hold_data`, clear `hold_full`, set `cur_is_data = 1`.
  - Otherwise: shift register ← `IDLE_BYTE`, `cur_is_data = 0`, pulse `underrun`.
  - `CIPO` ← bit 7 of the loaded byte.
- `sclk_rise` while ACTIVE: `bit_cnt` ← `bit_cnt + 1` (3-bit, wraps 7→0). On wrap to 0, pulse `byte_sent` if `cur_is_data`.
- `sclk_fall` while ACTIVE with `bit_cnt != 0`: shift left and drive the next bit on `CIPO`.
- **Deassert** (`cs_rise`):
  - `bit_cnt` ← 0, `cipo_oe` ← 0, `CIPO` ← 0.
  - If `bit_cnt != 0`, pulse `frame_abort`. The partial byte is discarded, not re-sent, and `byte_sent` does not pulse.
  - The holding register is untouched.
- **Simultaneous write and load** in one cycle: the load takes the old `hold_data`. The write is not accepted because `tx_ready` was low. A write is never lost or duplicated.
- `cs_fall` and `cs_rise` in the same cycle cannot occur after synchronization. CS glitches shorter than one `clk` period may be dropped.

## Timing
- **Reset values:** `CIPO` 0, `cipo_oe` 0, `tx_ready` 1, `byte_sent` 0, `underrun` 0, `frame_abort` 0, state IDLE, `bit_cnt` 0, `hold_full` 0.
- **Latency:** pin edge → edge-detect pulse is `SYNC_STAGES + 1` `clk` cycles. `CIPO`/`cipo_oe` update on the cycle after that pulse (3 cycles + 1 register with default parameters).
- **Frequency constraint:** SCLK high and low times ≥ `SYNC_STAGES + 3` `clk` periods (≥ 5 at default). This guarantees `CIPO` is stable before the host's rising-edge sample. Minimum CS-assert-to-first-SCLK-rise is the same.
- **Handshake:**
  - Write accepted at cycle N → `tx_ready` low from N+1.
  - Load event at cycle M → `tx_ready` high from M+1.
  - `tx_valid` may stay high; the FSM must hold `tx_data` stable until accepted.
- **Pulse timing:**
  - `byte_sent` is asserted the cycle after the 8th `sclk_rise` is detected.
  - `underrun` is asserted the cycle after the load event.
  - `frame_abort` is asserted the cycle after `cs_rise`.
- **Asynchronous reset mid-frame:** all state returns to reset values immediately. The held byte is lost.

## Test plan
- Write 8'hA7 while IDLE, then CS low and 8 SCLK cycles at clk/12 → host samples 1010_0111. `byte_sent` pulses once, `underrun` never, and `tx_ready` is high after CS assert.
- Write 8'h3C, CS low, 16 SCLK cycles with no second write → host sees 8'h3C then 8'hFF. `byte_sent` ×1, `underrun` ×1 at the second byte boundary.
- Back-to-back: write 8'h01, start the frame, then write 8'h80 during bit 3 → host sees 8'h01, 8'h80, with no underrun. `tx_ready` stays low between the second write and the second load.
- Abort: write 8'hF0, CS low, 4 SCLK cycles, CS high → `frame_abort` ×1, no `byte_sent`, `cipo_oe` goes low. The next frame (no new write) returns 8'hFF with `underrun`.
- SCLK toggling with CS high → `CIPO`/`cipo_oe` stay 0, `bit_cnt` stays 0, and the held byte remains held.
- Assert `rst_n` low during bit 5 of 8'h55 → all outputs at reset values within the same cycle. After release, `tx_ready` = 1 and the next frame sends `IDLE_BYTE`.
